// File: rtl/draw_port_arbiter.sv
// Round-robin owner of the single VGA pixel-write port, shared by the drawing units.
// Latency: grant 1 cycle after req in IDLE; pixel path 1 cycle; 3-cycle release-to-next-grant turnaround.
// Backpressure: a drawer owns the port from grant until release; a watchdog reclaims it after TIMEOUT idle cycles.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   req                  per-drawer level request (index 0 background .. 5 number)
//   release_in           per-drawer end-of-burst strobe ("release" is a reserved word)
//   plot_in              per-drawer pixel valid
//   x_in/y_in/colour_in  packed per-drawer pixel data, drawer i at [i*W +: W]
//   grant                registered one-hot grant
//   vga_x/y/colour/plot  registered pixel write to the VGA adapter
//   busy                 registered, high while a burst owns the port
//   pixel_count          plots forwarded in the current/last grant (saturating)
//   timeout_err          one-cycle pulse when the watchdog reclaims the port
module draw_port_arbiter #(
  parameter int NUM_REQ  = 6,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           release_in,
  input  logic [NUM_REQ-1:0]           plot_in,
  input  logic [NUM_REQ*X_W-1:0]       x_in,
  input  logic [NUM_REQ*Y_W-1:0]       y_in,
  input  logic [NUM_REQ*COLOUR_W-1:0]  colour_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic [15:0]                  pixel_count,
  output logic                         timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  gidx;     // index of the current/last owner
  logic [WW-1:0]  wd_cnt;

  // Winner search: walk downward from the farthest candidate so the last hit
  // is the first requester at or after rr_ptr (wrapping).
  logic [IW:0]    cand;
  logic [IW-1:0]  win_idx;
  logic           win_vld;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Owner's view of the shared inputs; other drawers are never looked at.
  logic                 plot_g, rel_g, req_g, wd_hit;
  logic [X_W-1:0]       x_g;
  logic [Y_W-1:0]       y_g;
  logic [COLOUR_W-1:0]  colour_g;

  assign plot_g   = plot_in[gidx];
  assign rel_g    = release_in[gidx];
  assign req_g    = req[gidx];
  assign x_g      = x_in[int'(gidx)*X_W +: X_W];
  assign y_g      = y_in[int'(gidx)*Y_W +: Y_W];
  assign colour_g = colour_in[int'(gidx)*COLOUR_W +: COLOUR_W];
  assign wd_hit   = !plot_g && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      wd_cnt      <= '0;
      grant       <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      busy        <= 1'b0;
      pixel_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          vga_plot <= 1'b0;
          if (win_vld) begin
            grant       <= NUM_REQ'(1) << win_idx;
            gidx        <= win_idx;
            pixel_count <= '0;
            wd_cnt      <= '0;
            busy        <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          // The pixel of the release cycle is still forwarded here.
          vga_x      <= x_g;
          vga_y      <= y_g;
          vga_colour <= colour_g;
          vga_plot   <= plot_g;
          if (plot_g && (pixel_count != 16'hFFFF)) pixel_count <= pixel_count + 16'd1;
          wd_cnt <= plot_g ? '0 : wd_cnt + WW'(1);
          if (rel_g || !req_g || wd_hit) begin
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= wd_hit;
            state       <= GAP;
          end
        end
        GAP: begin
          vga_plot <= 1'b0;
          rr_ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
